button_press_ledr: RTL and testbench

BUTTON_PRESS_LEDR -- requirements
Module: button_press_ledr

---
 rtl/button_press_ledr.sv | 84 ++++++++
 tb/tb_button_press_ledr.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_ledr.sv
// Debounced push-button to red LED, with press strobe and optional toggle.
// Ports:
//   clk         - rising-edge system clock
//   rst_n       - synchronous active-low reset
//   button      - raw, asynchronous, bouncing push-button level
//   LEDR        - registered LED drive at physical polarity (LED_ACTIVE_LOW)
//   pressed     - registered debounced press state, 1 = pressed
//   press_pulse - one-cycle registered strobe on each accepted press
module button_press_ledr #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter bit BUTTON_ACTIVE_LOW = 1'b0,
    parameter bit LED_ACTIVE_LOW    = 1'b0,
    parameter bit TOGGLE_MODE       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic LEDR,
    output logic pressed,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    // Raw pin level that means "not pressed"; synchronizer resets here.
    localparam logic RELEASED = BUTTON_ACTIVE_LOW;

    logic          s1;
    logic          s2;
    logic          db;
    logic [CW-1:0] cnt;
    logic          led;

    logic level;
    logic rise;
    logic led_next;

    assign level = s2 ^ BUTTON_ACTIVE_LOW;
    // db has just gone high but pressed has not yet followed.
    assign rise  = db & ~pressed;

    always_comb begin
        led_next = led;
        if (TOGGLE_MODE) begin
            if (rise) begin
                led_next = ~led;
            end
        end else begin
            led_next = db;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1          <= RELEASED;
            s2          <= RELEASED;
            db          <= 1'b0;
            cnt         <= '0;
            pressed     <= 1'b0;
            press_pulse <= 1'b0;
            led         <= 1'b0;
            LEDR        <= LED_ACTIVE_LOW;
        end else begin
            s1 <= button;
            s2 <= s1;
            // Count consecutive disagreeing samples; any agreement restarts.
            if (level != db) begin
                if (cnt == CNT_MAX) begin
                    db  <= level;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
            pressed     <= db;
            press_pulse <= rise;
            led         <= led_next;
            LEDR        <= led_next ^ LED_ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_button_press_ledr.sv
// Self-checking bench for button_press_ledr with DEBOUNCE_CYCLES=4.
// Three instances (follow, toggle, inverted polarity) share one stimulus.
module tb_button_press_ledr;

    localparam int DB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic btn_p;
    assign btn_p = ~btn;

    logic ledr_f, pressed_f, pulse_f;
    logic ledr_t, pressed_t, pulse_t;
    logic ledr_p, pressed_p, pulse_p;

    button_press_ledr #(
        .DEBOUNCE_CYCLES(DB)
    ) dut_f (
        .clk(clk), .rst_n(rst_n), .button(btn),
        .LEDR(ledr_f), .pressed(pressed_f), .press_pulse(pulse_f)
    );

    button_press_ledr #(
        .DEBOUNCE_CYCLES(DB), .TOGGLE_MODE(1'b1)
    ) dut_t (
        .clk(clk), .rst_n(rst_n), .button(btn),
        .LEDR(ledr_t), .pressed(pressed_t), .press_pulse(pulse_t)
    );

    button_press_ledr #(
        .DEBOUNCE_CYCLES(DB), .BUTTON_ACTIVE_LOW(1'b1), .LED_ACTIVE_LOW(1'b1)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .button(btn_p),
        .LEDR(ledr_p), .pressed(pressed_p), .press_pulse(pulse_p)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: logical button samples per edge, and the window of
    // samples that have cleared the two-stage synchronizer.
    bit q_samp[$] = '{1'b0, 1'b0};
    bit ev[$];
    bit m_db = 1'b0;
    bit m_pressed = 1'b0;
    bit m_pulse = 1'b0;
    bit m_led_t = 1'b0;

    task automatic tick();
        bit nd, np, npu, nl, flip;
        @(posedge clk);
        if (!rst_n) begin
            q_samp = '{1'b0, 1'b0};
            ev = {};
            m_db = 1'b0;
            m_pressed = 1'b0;
            m_pulse = 1'b0;
            m_led_t = 1'b0;
        end else begin
            q_samp.push_back(btn);
            if (q_samp.size() > 3) void'(q_samp.pop_front());
            ev.push_back(q_samp[0]);
            if (ev.size() > DB) void'(ev.pop_front());
            np = m_db;
            npu = m_db & !m_pressed;
            nl = m_led_t ^ npu;
            nd = m_db;
            if (ev.size() == DB) begin
                flip = 1'b1;
                foreach (ev[k]) if (ev[k] == m_db) flip = 1'b0;
                if (flip) nd = !m_db;
            end
            m_db = nd;
            m_pressed = np;
            m_pulse = npu;
            m_led_t = nl;
        end
        #1;
    endtask

    function automatic logic [8:0] obs();
        return {pressed_f, pulse_f, ledr_f, pressed_t, pulse_t, ledr_t,
                pressed_p, pulse_p, ledr_p};
    endfunction

    function automatic logic [8:0] expv();
        return {m_pressed, m_pulse, m_pressed, m_pressed, m_pulse, m_led_t,
                m_pressed, m_pulse, !m_pressed};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        btn = 1'b0;
        repeat (2) tick();
        checks++;
        if ({ledr_f, ledr_p, ledr_t, pressed_f, pulse_f} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_state: got %b want 01000",
                     {ledr_f, ledr_p, ledr_t, pressed_f, pulse_f});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %b want %b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_follow();
        int pulses = 0;
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            pulses += int'(pulse_f);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL follow_rise_model[%0d]: got %b want %b", i, obs(), expv());
            end
            if (i == 6) begin
                checks++;
                if (ledr_f !== 1'b0) begin
                    errors++;
                    $display("FAIL follow_early: LEDR got %b want 0", ledr_f);
                end
            end
            if (i == 7) begin
                checks++;
                if ({ledr_f, pressed_f, pulse_f} !== 3'b111) begin
                    errors++;
                    $display("FAIL follow_edge7: got %b want 111",
                             {ledr_f, pressed_f, pulse_f});
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL follow_pulses: got %0d want 1", pulses);
        end
        pulses = 0;
        btn = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            pulses += int'(pulse_f);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL follow_fall_model[%0d]: got %b want %b", i, obs(), expv());
            end
            if (i == 6 || i == 7) begin
                checks++;
                if ({ledr_f, pressed_f} !== ((i == 6) ? 2'b11 : 2'b00)) begin
                    errors++;
                    $display("FAIL follow_fall_edge%0d: got %b", i, {ledr_f, pressed_f});
                end
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL release_pulse: got %0d want 0", pulses);
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 13; i++) begin
            btn = (i < 3);
            tick();
            checks++;
            if ({ledr_f, pressed_f, pulse_f} !== 3'b000 || obs() !== expv()) begin
                errors++;
                $display("FAIL glitch[%0d]: got %b want %b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_bounce();
        bit pat[10];
        int pulses = 0;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 16; i++) begin
            btn = (i < 10) ? pat[i] : 1'b1;
            tick();
            pulses += int'(pulse_f);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL bounce_model[%0d]: got %b want %b", i, obs(), expv());
            end
            if (i == 10 || i == 11) begin
                checks++;
                if (ledr_f !== (i == 11)) begin
                    errors++;
                    $display("FAIL bounce_led[%0d]: got %b want %b", i, ledr_f, i == 11);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_pulses: got %0d want 1", pulses);
        end
        btn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_toggle();
        bit want;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int p = 0; p < 3; p++) begin
            want = (p % 2 == 0);
            for (int h = 0; h < 2; h++) begin
                btn = (h == 0);
                for (int i = 0; i < 10; i++) begin
                    tick();
                    checks++;
                    if (obs() !== expv()) begin
                        errors++;
                        $display("FAIL toggle_model[%0d.%0d.%0d]: got %b want %b",
                                 p, h, i, obs(), expv());
                    end
                end
                checks++;
                if (ledr_t !== want) begin
                    errors++;
                    $display("FAIL toggle_led[%0d.%0d]: got %b want %b", p, h, ledr_t, want);
                end
            end
        end
    endtask

    task automatic test_polarity();
        checks++;
        if ({ledr_p, pressed_p} !== 2'b10) begin
            errors++;
            $display("FAIL polarity_idle: got %b want 10", {ledr_p, pressed_p});
        end
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL polarity_model[%0d]: got %b want %b", i, obs(), expv());
            end
            if (i == 6 || i == 7) begin
                checks++;
                if (ledr_p !== (i == 6)) begin
                    errors++;
                    $display("FAIL polarity_led[%0d]: got %b want %b", i, ledr_p, i == 6);
                end
            end
        end
        btn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        btn = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({pressed_f, pulse_f, ledr_f, ledr_t, ledr_p} !== 5'b00001) begin
                errors++;
                $display("FAIL reset_mid_hold[%0d]: got %b want 00001",
                         i, {pressed_f, pulse_f, ledr_f, ledr_t, ledr_p});
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_mid_model[%0d]: got %b want %b", i, obs(), expv());
            end
            if (i == 6 || i == 7) begin
                checks++;
                if ({ledr_f, ledr_t} !== ((i == 7) ? 2'b11 : 2'b00)) begin
                    errors++;
                    $display("FAIL reset_mid_led[%0d]: got %b", i, {ledr_f, ledr_t});
                end
            end
        end
        btn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int len;
        for (int s = 0; s < 60; s++) begin
            btn = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            if ($urandom_range(0, 19) == 0) rst_n = 1'b0;
            for (int i = 0; i < len; i++) begin
                tick();
                rst_n = 1'b1;
                checks++;
                if (obs() !== expv()) begin
                    errors++;
                    $display("FAIL random[%0d.%0d]: got %b want %b", s, i, obs(), expv());
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_follow();
        test_glitch();
        test_bounce();
        test_toggle();
        test_polarity();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
